// File: rtl/cpu_bus_bridge.sv
// CPU bus slave bridge: decodes one four-phase request per strobe and routes it to a
// byte-wide synchronous RAM, a byte-wide I/O page, or an error response.
module cpu_bus_bridge #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter logic [7:0]  IO_PAGE    = 8'hFF,
  parameter int unsigned MEM_WAIT   = 1,
  parameter int unsigned IO_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bus_clk,
  input  logic              i_bus_we,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic [DATA_W-1:0] i_bus_data,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_bus_data_ready,
  output logic              o_bus_err,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [15:0]       o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_io_sel,
  output logic              o_io_we,
  output logic [7:0]        o_io_addr,
  output logic [7:0]        o_io_wdata,
  input  logic [7:0]        i_io_rdata,
  input  logic              i_io_ready
);

  localparam int unsigned CntW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam int unsigned ToW  = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

  typedef enum logic [2:0] {StIdle, StMemEn, StMemWt, StIo, StResp} state_e;

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  // Only the low byte of write data is ever forwarded.
  logic unused_data_bits;
  assign unused_data_bits = ^i_bus_data[DATA_W-1:8];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_bus_clk) begin
          addr_d  = i_bus_addr[15:0];
          we_d    = i_bus_we;
          wdata_d = i_bus_data[7:0];
          if (i_bus_addr[ADDR_W-1:16] != '0) begin
            state_d = StResp;
            err_d   = 1'b1;
            if (!i_bus_we) rdata_d = '0;
          end else if (i_bus_addr[15:8] == IO_PAGE) begin
            state_d = StIo;
            to_d    = '0;
          end else begin
            state_d = StMemEn;
          end
        end
      end
      StMemEn: begin
        state_d = StMemWt;
        cnt_d   = CntW'(MEM_WAIT - 1);
      end
      StMemWt: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          err_d   = 1'b0;
          if (!we_q) rdata_d = DATA_W'(i_mem_rdata);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StIo: begin
        // A ready in the final timeout cycle still wins over the timeout.
        if (i_io_ready) begin
          state_d = StResp;
          err_d   = 1'b0;
          if (!we_q) rdata_d = DATA_W'(i_io_rdata);
        end else if (to_q == ToW'(IO_TIMEOUT - 1)) begin
          state_d = StResp;
          err_d   = 1'b1;
          if (!we_q) rdata_d = DATA_W'(8'hFF);
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StResp: begin
        if (!i_bus_clk) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_bus_data       = rdata_q;
  assign o_bus_data_ready = (state_q == StResp);
  assign o_bus_err        = err_q;
  assign o_mem_en         = (state_q == StMemEn);
  assign o_mem_we         = o_mem_en & we_q;
  assign o_mem_addr       = addr_q;
  assign o_mem_wdata      = wdata_q;
  assign o_io_sel         = (state_q == StIo);
  assign o_io_we          = o_io_sel & we_q;
  assign o_io_addr        = addr_q[7:0];
  assign o_io_wdata       = wdata_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Bench for cpu_bus_bridge: transaction-level model compared every cycle, plus directed
// accesses with hand-computed latencies and data.
module tb_cpu_bus_bridge;
  localparam int MemWait   = 1;
  localparam int IoTimeout = 16;
  localparam int KMem      = 0;
  localparam int KIo       = 1;

  logic        i_clk = 1'b0;
  logic        i_rst, i_bus_clk, i_bus_we, i_io_ready;
  logic [31:0] i_bus_addr, i_bus_data;
  logic [7:0]  i_mem_rdata = 8'h00;
  logic [7:0]  i_io_rdata;
  logic [31:0] o_bus_data;
  logic        o_bus_data_ready, o_bus_err, o_mem_en, o_mem_we, o_io_sel, o_io_we;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata, o_io_addr, o_io_wdata;

  int n_checks = 0;
  int n_errors = 0;
  logic started = 1'b0;

  cpu_bus_bridge #(
    .ADDR_W(32), .DATA_W(32), .IO_PAGE(8'hFF), .MEM_WAIT(MemWait), .IO_TIMEOUT(IoTimeout)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bus_clk(i_bus_clk), .i_bus_we(i_bus_we),
    .i_bus_addr(i_bus_addr), .i_bus_data(i_bus_data), .o_bus_data(o_bus_data),
    .o_bus_data_ready(o_bus_data_ready), .o_bus_err(o_bus_err), .o_mem_en(o_mem_en),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_io_sel(o_io_sel), .o_io_we(o_io_we),
    .o_io_addr(o_io_addr), .o_io_wdata(o_io_wdata), .i_io_rdata(i_io_rdata),
    .i_io_ready(i_io_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM device plus preload path
  logic        pre_en;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  ram [0:65535];
  always @(posedge i_clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (o_mem_en) begin
      if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
      else i_mem_rdata <= ram[o_mem_addr];
    end
  end

  // Transaction model: one access in flight, answered after a fixed or I/O-driven number
  // of edges counted from the accepting edge.
  logic [7:0]  shadow [0:65535];
  logic        m_busy = 1'b0, m_resp = 1'b0, m_err = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_data = '0;
  logic [7:0]  m_wdata = '0;
  int          m_kind = 0, m_age = 0;

  always @(posedge i_clk) begin
    if (pre_en) shadow[pre_addr] <= pre_data;
    if (i_rst) begin
      m_busy <= 1'b0; m_resp <= 1'b0; m_err <= 1'b0; m_data <= '0; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_age <= 0;
    end else if (m_resp) begin
      if (!i_bus_clk) begin m_resp <= 1'b0; m_err <= 1'b0; end
    end else if (m_busy) begin
      m_age <= m_age + 1;
      if (m_kind == KMem && m_age + 1 == MemWait + 1) begin
        m_busy <= 1'b0; m_resp <= 1'b1; m_err <= 1'b0;
        if (!m_we) m_data <= {24'h0, shadow[m_addr[15:0]]};
      end else if (m_kind == KIo && i_io_ready) begin
        m_busy <= 1'b0; m_resp <= 1'b1; m_err <= 1'b0;
        if (!m_we) m_data <= {24'h0, i_io_rdata};
      end else if (m_kind == KIo && m_age + 1 == IoTimeout) begin
        m_busy <= 1'b0; m_resp <= 1'b1; m_err <= 1'b1;
        if (!m_we) m_data <= 32'h0000_00FF;
      end
    end else if (i_bus_clk) begin
      m_addr <= i_bus_addr; m_we <= i_bus_we; m_wdata <= i_bus_data[7:0]; m_age <= 0;
      if (i_bus_addr >= 32'h0001_0000) begin
        m_resp <= 1'b1; m_err <= 1'b1;
        if (!i_bus_we) m_data <= '0;
      end else if (i_bus_addr[15:8] == 8'hFF) begin
        m_busy <= 1'b1; m_kind <= KIo;
      end else begin
        m_busy <= 1'b1; m_kind <= KMem;
        if (i_bus_we) shadow[i_bus_addr[15:0]] <= i_bus_data[7:0];
      end
    end
  end

  always @(negedge i_clk) begin
    if (started) begin
      logic exp_mem, exp_io;
      exp_mem = m_busy && m_kind == KMem && m_age == 0;
      exp_io  = m_busy && m_kind == KIo;
      check("bus_ready", {31'h0, o_bus_data_ready}, {31'h0, m_resp});
      check("bus_err", {31'h0, o_bus_err}, {31'h0, m_err});
      check("bus_data", o_bus_data, m_data);
      check("mem_en", {31'h0, o_mem_en}, {31'h0, exp_mem});
      check("mem_we", {31'h0, o_mem_we}, {31'h0, exp_mem && m_we});
      check("io_sel", {31'h0, o_io_sel}, {31'h0, exp_io});
      check("io_we", {31'h0, o_io_we}, {31'h0, exp_io && m_we});
      if (exp_mem) begin
        check("mem_addr", {16'h0, o_mem_addr}, {16'h0, m_addr[15:0]});
        check("mem_wdata", {24'h0, o_mem_wdata}, {24'h0, m_wdata});
      end
      if (exp_io) begin
        check("io_addr", {24'h0, o_io_addr}, {24'h0, m_addr[7:0]});
        check("io_wdata", {24'h0, o_io_wdata}, {24'h0, m_wdata});
      end
    end
  end

  // Issue one request at a negedge; returns the number of negedges until ready is seen.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input int io_at, input logic [7:0] io_data, input int drop_at,
                           output int lat, output int n_mem, output int n_io, output int n_wr);
    i_bus_clk = 1'b1; i_bus_we = we; i_bus_addr = addr; i_bus_data = data;
    i_io_rdata = io_data;
    lat = 0; n_mem = 0; n_io = 0; n_wr = 0;
    do begin
      @(negedge i_clk);
      lat++;
      if (o_mem_en) n_mem++;
      if (o_io_sel) n_io++;
      if (o_mem_we || o_io_we) n_wr++;
      i_io_ready = (lat == io_at);
      if (lat == drop_at) i_bus_clk = 1'b0;
    end while (!o_bus_data_ready && lat < 40);
    i_io_ready = 1'b0;
    check("ready_seen", {31'h0, o_bus_data_ready}, 32'h1);
  endtask

  task automatic release_strobe(input int hold);
    int n_rdy = 0;
    int n_mem = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      if (o_bus_data_ready) n_rdy++;
      if (o_mem_en || o_io_sel) n_mem++;
    end
    check("hold_ready_cycles", n_rdy, hold);
    check("hold_no_access", n_mem, 0);
    i_bus_clk = 1'b0;
    @(negedge i_clk);
    check("ready_drop", {31'h0, o_bus_data_ready}, 32'h0);
  endtask

  initial begin
    int lat, nm, ni, nw;
    i_rst = 1'b1; i_bus_clk = 1'b0; i_bus_we = 1'b0; i_bus_addr = '0; i_bus_data = '0;
    i_io_ready = 1'b0; i_io_rdata = '0;
    pre_en = 1'b1; pre_addr = 16'h1234; pre_data = 8'hA5;
    @(posedge i_clk);
    started = 1'b1;
    @(negedge i_clk);
    pre_en = 1'b0;
    @(negedge i_clk);
    check("rst_ready", {31'h0, o_bus_data_ready}, 32'h0);
    check("rst_data", o_bus_data, 32'h0);
    check("rst_mem_addr", {16'h0, o_mem_addr}, 32'h0);
    check("rst_io_addr", {24'h0, o_io_addr}, 32'h0);
    check("rst_wdata", {16'h0, o_mem_wdata, o_io_wdata}, 32'h0);
    i_rst = 1'b0;

    do_access(1'b0, 32'h0000_1234, 32'h0, -1, 8'h00, -1, lat, nm, ni, nw);
    check("mem_rd_latency", lat, 3);
    check("mem_rd_pulses", nm, 1);
    check("mem_rd_data", o_bus_data, 32'h0000_00A5);
    check("mem_rd_err", {31'h0, o_bus_err}, 32'h0);
    release_strobe(0);

    do_access(1'b1, 32'h0000_0042, 32'hDEAD_BE77, -1, 8'h00, -1, lat, nm, ni, nw);
    check("mem_wr_latency", lat, 3);
    check("mem_wr_pulses", nm, 1);
    check("mem_wr_we", nw, 1);
    check("mem_wr_keep_data", o_bus_data, 32'h0000_00A5);
    release_strobe(0);
    check("ram_0042", {24'h0, ram[16'h0042]}, 32'h77);

    do_access(1'b0, 32'h0000_FF10, 32'h0, 3, 8'h3C, -1, lat, nm, ni, nw);
    check("io_rd_latency", lat, 4);
    check("io_rd_sel_cycles", ni, 3);
    check("io_rd_data", o_bus_data, 32'h0000_003C);
    check("io_rd_err", {31'h0, o_bus_err}, 32'h0);
    release_strobe(0);

    do_access(1'b0, 32'h0000_FF20, 32'h0, -1, 8'h55, -1, lat, nm, ni, nw);
    check("io_to_latency", lat, 17);
    check("io_to_sel_cycles", ni, 16);
    check("io_to_data", o_bus_data, 32'h0000_00FF);
    check("io_to_err", {31'h0, o_bus_err}, 32'h1);
    release_strobe(0);

    do_access(1'b1, 32'h0000_FF05, 32'h0000_0099, 1, 8'h00, -1, lat, nm, ni, nw);
    check("io_wr_fast_latency", lat, 2);
    check("io_wr_fast_sel", ni, 1);
    check("io_wr_keep_data", o_bus_data, 32'h0000_00FF);
    release_strobe(0);

    do_access(1'b0, 32'h0001_0000, 32'h0, -1, 8'h00, -1, lat, nm, ni, nw);
    check("unmapped_latency", lat, 1);
    check("unmapped_strobes", nm + ni, 0);
    check("unmapped_data", o_bus_data, 32'h0);
    check("unmapped_err", {31'h0, o_bus_err}, 32'h1);
    release_strobe(0);

    do_access(1'b0, 32'h0000_1234, 32'h0, -1, 8'h00, -1, lat, nm, ni, nw);
    release_strobe(10);
    check("hold_data", o_bus_data, 32'h0000_00A5);

    do_access(1'b0, 32'h0000_0042, 32'h0, -1, 8'h00, 1, lat, nm, ni, nw);
    check("early_drop_latency", lat, 3);
    check("early_drop_data", o_bus_data, 32'h0000_0077);
    release_strobe(0);

    i_bus_clk = 1'b1; i_bus_we = 1'b0; i_bus_addr = 32'h0000_1234;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1; i_bus_clk = 1'b0;
    @(negedge i_clk);
    check("midrst_ready", {31'h0, o_bus_data_ready}, 32'h0);
    check("midrst_data", o_bus_data, 32'h0);
    check("midrst_mem_addr", {16'h0, o_mem_addr}, 32'h0);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check("midrst_no_ready", {31'h0, o_bus_data_ready}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
